buffer_sum_sched: RTL

BUFFER_SUM_SCHED -- requirements
Module: buffer_sum_sched

---
 rtl/buffer_sum_sched.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/buffer_sum_sched.sv
// buffer_sum_sched
//
// Purpose: a four-slot register bank. Four requesters write into it through a
// round-robin arbiter, and a small sequencer sums the four slots on request.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   req[3:0]   write requests, bit i from requester i
//   wdata      requester i data at wdata[i*DW +: DW]
//   gnt[3:0]   one-hot grant (combinational); the write happens at the next edge
//   mode_o     slot-select encoding of the most recent write
//   sum_start  start a summation (sampled only in IDLE)
//   sum_busy   high in ACC and DONE
//   sum_valid  one-cycle completion pulse (the DONE cycle)
//   sum_o      result of the last completed summation
//   rd_idx     slot index for the combinational read port
//   rd_data    content of slot rd_idx
//   state_dbg  current sequencer state (0 IDLE, 1 ACC, 2 DONE)
//
// Optional feature: define SUM_SAT_EN to make sum_o saturate to all-ones.
// Without it, sum_o is the accumulator modulo 2^DW.
//
// Handshake: a requester holds req[i] and wdata[i] until it sees gnt[i] high.
// The slot loads on the rising edge where gnt[i] is high. No grant is issued
// while the sequencer is busy or the block is in reset.

module buffer_sum_sched #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      req,
    input  logic [4*DW-1:0] wdata,
    output logic [3:0]      gnt,
    output logic [3:0]      mode_o,
    input  logic            sum_start,
    output logic            sum_busy,
    output logic            sum_valid,
    output logic [DW-1:0]   sum_o,
    input  logic [1:0]      rd_idx,
    output logic [DW-1:0]   rd_data,
    output logic [1:0]      state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [DW-1:0]   slot [4];
    logic [1:0]      last_gnt;
    logic [1:0]      gnt_idx;
    logic            gnt_any;
    logic [DW+1:0]   acc;
    logic [DW+1:0]   acc_sum;
    logic [1:0]      idx;
    logic [DW-1:0]   sum_res;

    // Round-robin search. It starts one past the last granted requester.
    // Reset leaves last_gnt at 3, so requester 0 has the highest priority.
    always_comb begin
        logic [1:0] cand;
        gnt     = 4'b0000;
        gnt_idx = 2'd0;
        gnt_any = 1'b0;
        cand    = 2'd0;
        if (rst_n && state == IDLE) begin
            for (int k = 0; k < 4; k++) begin
                cand = last_gnt + 2'(k + 1);
                if (!gnt_any && req[cand]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand;
                end
            end
            if (gnt_any) gnt[gnt_idx] = 1'b1;
        end
    end

    function automatic logic [3:0] mode_enc(input logic [1:0] s);
        case (s)
            2'd0:    mode_enc = 4'b1100;
            2'd1:    mode_enc = 4'b1000;
            2'd2:    mode_enc = 4'b0010;
            default: mode_enc = 4'b0000;
        endcase
    endfunction

    // Sequencer next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sum_start) state_next = ACC;
            ACC:     if (idx == 2'd3) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign acc_sum = acc + {2'b00, slot[idx]};

    // The final addition feeds sum_o directly, so the result is
    // registered on the same edge that enters DONE.
`ifdef SUM_SAT_EN
    assign sum_res = (acc_sum > {2'b00, {DW{1'b1}}}) ? {DW{1'b1}} : acc_sum[DW-1:0];
`else
    assign sum_res = acc_sum[DW-1:0];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) slot[i] <= '0;
            last_gnt  <= 2'd3;
            mode_o    <= 4'b0000;
            state     <= IDLE;
            acc       <= '0;
            idx       <= 2'd0;
            sum_o     <= '0;
            sum_valid <= 1'b0;
        end else begin
            state <= state_next;
            if (gnt_any) begin
                slot[gnt_idx] <= wdata[gnt_idx*DW +: DW];
                last_gnt      <= gnt_idx;
                mode_o        <= mode_enc(gnt_idx);
            end
            case (state)
                IDLE: begin
                    if (sum_start) begin
                        acc <= '0;
                        idx <= 2'd0;
                    end
                end
                ACC: begin
                    acc <= acc_sum;
                    idx <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        sum_o     <= sum_res;
                        sum_valid <= 1'b1;
                    end
                end
                DONE: begin
                    sum_valid <= 1'b0;
                end
                default: begin
                    sum_valid <= 1'b0;
                end
            endcase
        end
    end

    assign sum_busy  = (state != IDLE);
    assign rd_data   = slot[rd_idx];
    assign state_dbg = state;

endmodule
